memory_dump_renderer: RTL and testbench

- Renders a configurable grid of memory words as hex text ("0xAAAAA DDDDDDDD") into the ASCII framebuffer, with an optional '*' border background pass.
- Parametrised successor to the fixed 80x60, 4x58 memory view. Adds:
  - configurable geometry, word width and memory read latency
  - row-/column-major ordering and refresh-only mode
  - address highlight colour and abort
- Sits between data memory (read port) and the ASCII framebuffer write port, and is triggered by the display controller.

---
 rtl/memory_dump_renderer.sv | 199 +++++++++++++++++++
 tb/tb_memory_dump_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_dump_renderer.sv
// Renders a grid of memory words as "0xAAAAA DDDDDDDD" text into the ASCII framebuffer,
// optionally preceded by a '*' border background pass.
module memory_dump_renderer #(
  parameter int          SCR_W       = 80,
  parameter int          SCR_H       = 60,
  parameter int          FB_AW       = 13,
  parameter int          NCOL        = 4,
  parameter int          NROW        = 58,
  parameter int          X0          = 5,
  parameter int          Y0          = 1,
  parameter int          PITCH       = 18,
  parameter int          ADDR_DIGITS = 5,
  parameter int          DATA_W      = 32,
  parameter int          MEM_AW      = 16,
  parameter int          MEM_LAT     = 1,
  parameter logic [23:0] FG_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] HL_COLOR    = 24'hFFFF00,
  localparam int         ADDR_W      = 4 * ADDR_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              refresh_only,
  input  logic              row_major,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              hl_en,
  input  logic [ADDR_W-1:0] hl_addr,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ascii_write_en,
  output logic [31:0]       ascii_input,
  output logic [FB_AW-1:0]  ascii_write_address,
  output logic              busy,
  output logic              done
);

  localparam int DATA_DIGITS = DATA_W / 4;
  localparam int E     = 3 + ADDR_DIGITS + DATA_DIGITS;
  localparam int NENT  = NCOL * NROW;
  localparam int NPIX  = SCR_W * SCR_H;
  localparam int BYTES = DATA_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int KW    = $clog2(NENT + 1);
  localparam int RW    = $clog2(NROW + 1);
  localparam int CW    = $clog2(NCOL + 1);
  localparam int HW    = $clog2(SCR_H + 1);
  localparam int WW    = $clog2(SCR_W + 1);
  localparam int NW    = $clog2(E + MEM_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_FETCH, S_WAIT, S_EMIT, S_FIN} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h37 + {4'h0, n};
  endfunction

  state_t            state_r, state_s;
  logic [FB_AW-1:0]  pix_r, pix_s;
  logic [HW-1:0]     bg_row_r, bg_row_s;
  logic [WW-1:0]     bg_col_r, bg_col_s;
  logic [NW-1:0]     cnt_r, cnt_s;
  logic [KW-1:0]     k_r, k_s;
  logic [RW-1:0]     row_r, row_s;
  logic [CW-1:0]     col_r, col_s;
  logic [ADDR_W-1:0] addr_r, addr_s, hl_addr_r, hl_addr_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              rm_r, rm_s, hl_en_r, hl_en_s, busy_r, busy_s, done_r, done_s;
  logic              rd_r, rd_s, we_r, we_s;
  logic [MEM_AW-1:0] maddr_r, maddr_s;
  logic [7:0]        char_s;
  logic [23:0]       color_s;
  logic [31:0]       ain_r;
  logic [FB_AW-1:0]  waddr_r, waddr_s;
  int                a_idx, d_idx;

  // Next-state and sequencing counters; abort overrides everything outside IDLE.
  always_comb begin
    state_s = state_r; pix_s = pix_r; bg_row_s = bg_row_r; bg_col_s = bg_col_r;
    cnt_s = cnt_r; k_s = k_r; row_s = row_r; col_s = col_r; addr_s = addr_r;
    hl_addr_s = hl_addr_r; data_s = data_r; rm_s = rm_r; hl_en_s = hl_en_r;
    busy_s = busy_r; done_s = done_r;
    if (abort && (state_r != S_IDLE)) begin
      state_s = S_IDLE; busy_s = 1'b0; done_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !abort) begin
            state_s = refresh_only ? S_FETCH : S_BG;
            pix_s = '0; bg_row_s = '0; bg_col_s = '0; k_s = '0; row_s = '0; col_s = '0;
            addr_s = start_addr; rm_s = row_major; hl_en_s = hl_en; hl_addr_s = hl_addr;
            busy_s = 1'b1; done_s = 1'b0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_BG: begin
          if (pix_r == FB_AW'(NPIX - 1)) begin
            state_s = S_FETCH;
          end else begin
            pix_s = pix_r + FB_AW'(1);
            if (bg_col_r == WW'(SCR_W - 1)) begin
              bg_col_s = '0; bg_row_s = bg_row_r + HW'(1);
            end else begin
              bg_col_s = bg_col_r + WW'(1);
            end
          end
        end
        S_FETCH: begin
          state_s = S_WAIT; cnt_s = '0;
        end
        S_WAIT: begin
          if (cnt_r == NW'(MEM_LAT - 1)) begin
            state_s = S_EMIT; cnt_s = '0; data_s = mem_data;
          end else begin
            cnt_s = cnt_r + NW'(1);
          end
        end
        S_EMIT: begin
          if (cnt_r != NW'(E - 1)) begin
            cnt_s = cnt_r + NW'(1);
          end else if (k_r == KW'(NENT - 1)) begin
            state_s = S_FIN;
          end else begin
            state_s = S_FETCH; k_s = k_r + KW'(1); addr_s = addr_r + ADDR_W'(BYTES);
            if (rm_r) begin
              if (col_r == CW'(NCOL - 1)) begin col_s = '0; row_s = row_r + RW'(1); end
              else begin col_s = col_r + CW'(1); end
            end else begin
              if (row_r == RW'(NROW - 1)) begin row_s = '0; col_s = col_r + CW'(1); end
              else begin row_s = row_r + RW'(1); end
            end
          end
        end
        S_FIN: begin
          state_s = S_IDLE; busy_s = 1'b0; done_s = 1'b1;
        end
        default: begin
          state_s = S_IDLE; busy_s = 1'b0; done_s = 1'b0;
        end
      endcase
    end
  end

  // Output values for the upcoming cycle, derived from next state so they line up with it.
  always_comb begin
    we_s = 1'b0; rd_s = (state_s == S_FETCH); maddr_s = MEM_AW'(addr_s >> SH);
    char_s = 8'h00; color_s = 24'h000000; waddr_s = '0;
    a_idx = ADDR_DIGITS + 1 - int'(cnt_s); d_idx = E - 1 - int'(cnt_s);
    case (state_s)
      S_BG: begin
        we_s = 1'b1; waddr_s = pix_s; color_s = FG_COLOR;
        if (bg_row_s == HW'(0) || bg_row_s == HW'(SCR_H - 1) ||
            bg_col_s == WW'(0) || bg_col_s == WW'(SCR_W - 1)) char_s = 8'h2A;
        else char_s = 8'h20;
      end
      S_EMIT: begin
        we_s = 1'b1;
        waddr_s = FB_AW'((Y0 + int'(row_s)) * SCR_W + X0 + int'(col_s) * PITCH + int'(cnt_s));
        color_s = (hl_en_s && (addr_s == hl_addr_s)) ? HL_COLOR : FG_COLOR;
        if (cnt_s == NW'(0))                    char_s = 8'h30;
        else if (cnt_s == NW'(1))               char_s = 8'h78;
        else if (cnt_s < NW'(2 + ADDR_DIGITS))  char_s = hex_char(addr_s[4*a_idx +: 4]);
        else if (cnt_s == NW'(2 + ADDR_DIGITS)) char_s = 8'h20;
        else                                    char_s = hex_char(data_s[4*d_idx +: 4]);
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE; pix_r <= '0; bg_row_r <= '0; bg_col_r <= '0; cnt_r <= '0;
      k_r <= '0; row_r <= '0; col_r <= '0; addr_r <= '0; hl_addr_r <= '0; data_r <= '0;
      rm_r <= 1'b0; hl_en_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
      rd_r <= 1'b0; maddr_r <= '0; we_r <= 1'b0; ain_r <= 32'h0; waddr_r <= '0;
    end else begin
      state_r <= state_s; pix_r <= pix_s; bg_row_r <= bg_row_s; bg_col_r <= bg_col_s;
      cnt_r <= cnt_s; k_r <= k_s; row_r <= row_s; col_r <= col_s; addr_r <= addr_s;
      hl_addr_r <= hl_addr_s; data_r <= data_s; rm_r <= rm_s; hl_en_r <= hl_en_s;
      busy_r <= busy_s; done_r <= done_s;
      rd_r <= rd_s; maddr_r <= maddr_s; we_r <= we_s; ain_r <= {char_s, color_s};
      waddr_r <= waddr_s;
    end
  end

  assign mem_rd              = rd_r;
  assign mem_addr            = maddr_r;
  assign ascii_write_en      = we_r;
  assign ascii_input         = ain_r;
  assign ascii_write_address = waddr_r;
  assign busy                = busy_r;
  assign done                = done_r;

endmodule

// File: tb/tb_memory_dump_renderer.sv
// Scoreboard bench: expected framebuffer writes are queued at start and popped per DUT write.
module tb_memory_dump_renderer;

  logic        clk = 1'b0, rst = 1'b0;
  logic        refresh_only = 1'b0, row_major = 1'b0, hl_en = 1'b0;
  logic [19:0] start_addr = 20'h0, hl_addr = 20'h0;
  logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;

  logic        a_rd, a_we, a_busy, a_done, b_rd, b_we, b_busy, b_done;
  logic [15:0] a_maddr, b_maddr;
  logic [31:0] a_mdata, b_mdata, a_in, b_in;
  logic [12:0] a_wa, b_wa;

  always #5 clk = ~clk;

  memory_dump_renderer u_a (
    .clk(clk), .rst(rst), .start(start_a), .refresh_only(refresh_only), .row_major(row_major),
    .abort(abort_a), .start_addr(start_addr), .hl_en(hl_en), .hl_addr(hl_addr),
    .mem_rd(a_rd), .mem_addr(a_maddr), .mem_data(a_mdata), .ascii_write_en(a_we),
    .ascii_input(a_in), .ascii_write_address(a_wa), .busy(a_busy), .done(a_done));

  memory_dump_renderer #(.MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .refresh_only(refresh_only), .row_major(row_major),
    .abort(abort_b), .start_addr(start_addr), .hl_en(hl_en), .hl_addr(hl_addr),
    .mem_rd(b_rd), .mem_addr(b_maddr), .mem_data(b_mdata), .ascii_write_en(b_we),
    .ascii_input(b_in), .ascii_write_address(b_wa), .busy(b_busy), .done(b_done));

  // Memory models: word n holds n; data is valid only in the cycle MEM_LAT after the read.
  logic        a_v = 1'b0;
  logic [31:0] a_d = 32'h0;
  logic [2:0]  b_v = 3'b000;
  logic [31:0] b_d0 = 32'h0, b_d1 = 32'h0, b_d2 = 32'h0;
  always @(posedge clk) begin
    a_v <= a_rd; a_d <= {16'h0, a_maddr};
    b_v <= {b_v[1:0], b_rd}; b_d0 <= {16'h0, b_maddr}; b_d1 <= b_d0; b_d2 <= b_d1;
  end
  assign a_mdata = a_v ? a_d : 32'hDEADBEEF;
  assign b_mdata = b_v[2] ? b_d2 : 32'hDEADBEEF;

  int n_assert = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [44:0] q_a[$], q_b[$];
  task automatic push(input int which, input logic [12:0] ad, input logic [31:0] d);
    if (which == 0) q_a.push_back({ad, d});
    else q_b.push_back({ad, d});
  endtask

  // Reference model of one full render, built from the textual format of each entry.
  task automatic model(input int which, input bit ro, input bit rm, input logic [19:0] sa,
                       input bit hl, input logic [19:0] ha);
    string hx = "0123456789ABCDEF";
    logic [19:0] a;
    logic [31:0] w;
    logic [23:0] col;
    logic [7:0]  ch[16];
    int r, c, b;
    if (!ro) begin
      for (int i = 0; i < 4800; i++) begin
        r = i / 80; c = i % 80;
        push(which, 13'(i), {((r == 0 || r == 59 || c == 0 || c == 79) ? 8'h2A : 8'h20), 24'hFFFFFF});
      end
    end
    for (int k = 0; k < 232; k++) begin
      a = sa + 20'(k * 4);
      w = 32'((a >> 2) & 20'h0FFFF);
      if (rm) begin r = k / 4; c = k % 4; end
      else begin r = k % 58; c = k / 58; end
      b = (1 + r) * 80 + 5 + c * 18;
      col = (hl && a == ha) ? 24'hFFFF00 : 24'hFFFFFF;
      ch[0] = 8'h30; ch[1] = 8'h78; ch[7] = 8'h20;
      for (int d = 0; d < 5; d++) ch[2+d] = hx[int'((a >> (4 * (4 - d))) & 20'hF)];
      for (int d = 0; d < 8; d++) ch[8+d] = hx[int'((w >> (4 * (7 - d))) & 32'hF)];
      for (int j = 0; j < 16; j++) push(which, 13'(b + j), {ch[j], col});
    end
  endtask

  // Write monitors: every DUT write must match the head of its expected queue.
  logic [44:0] a_exp, b_exp;
  logic        a_done_q = 1'b0, b_done_q = 1'b0;
  int a_first = -1, a_done_at = -1, a_rd_cnt = 0, b_done_at = -1;
  int b_rd_cyc[$];
  always @(negedge clk) begin
    if (a_we) begin
      if (a_first < 0) a_first = cyc;
      a_exp = (q_a.size() > 0) ? q_a.pop_front() : '1;
      check("a_write", {19'h0, a_wa, a_in}, {19'h0, a_exp});
    end
    if (a_done && !a_done_q) a_done_at = cyc;
    if (a_rd) a_rd_cnt++;
    a_done_q = a_done;
    if (b_we) begin
      b_exp = (q_b.size() > 0) ? q_b.pop_front() : '1;
      check("b_write", {19'h0, b_wa, b_in}, {19'h0, b_exp});
    end
    if (b_done && !b_done_q) b_done_at = cyc;
    if (b_rd) b_rd_cyc.push_back(cyc);
    b_done_q = b_done;
  end

  int acc;
  task automatic go_a();
    @(negedge clk); start_a = 1'b1; acc = cyc;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_a(input int limit);
    int n = 0;
    while (a_done_at < 0 && n < limit) begin @(negedge clk); n++; end
    check("a_done_timeout", 64'(a_done_at >= 0), 64'd1);
    check("a_queue_drained", 64'(q_a.size()), 64'd0);
  endtask

  initial begin
    int rd0, n;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {a_rd, a_maddr, a_we, a_in, a_wa, a_busy, a_done}, 64'd0);
    check("reset_outputs_b", {b_rd, b_maddr, b_we, b_in, b_wa, b_busy, b_done}, 64'd0);
    rst = 1'b1;

    // Reset in the middle of the background pass.
    model(0, 1'b0, 1'b0, 20'h00100, 1'b0, 20'h0);
    go_a();
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("midbg_reset", {a_rd, a_maddr, a_we, a_in, a_wa, a_busy, a_done}, 64'd0);
    q_a.delete();
    @(negedge clk); rst = 1'b1;

    // Full default render with background, column-major.
    model(0, 1'b0, 1'b0, 20'h00100, 1'b0, 20'h0);
    a_first = -1; a_done_at = -1;
    start_addr = 20'h00100;
    go_a();
    check("busy_set", {a_busy, a_done}, 64'd2);
    wait_a(20000);
    check("done_latency", 64'(a_done_at - a_first), 64'd8977);
    repeat (5) @(negedge clk);
    check("done_held", {a_busy, a_done}, 64'd1);

    // Row-major, refresh only: no background, first write 3 cycles after accept.
    model(0, 1'b1, 1'b1, 20'h00000, 1'b0, 20'h0);
    refresh_only = 1'b1; row_major = 1'b1; start_addr = 20'h00000;
    a_first = -1; a_done_at = -1;
    go_a();
    check("done_cleared", {a_busy, a_done}, 64'd2);
    wait_a(10000);
    check("first_write_latency", 64'(a_first - acc), 64'd3);

    // MEM_LAT=3 instance with address wrap.
    model(1, 1'b1, 1'b0, 20'hFFFFC, 1'b0, 20'h0);
    row_major = 1'b0; start_addr = 20'hFFFFC;
    b_rd_cyc.delete(); b_done_at = -1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (b_done_at < 0 && n < 10000) begin @(negedge clk); n++; end
    check("b_done_timeout", 64'(b_done_at >= 0), 64'd1);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);
    check("b_rd_count", 64'(b_rd_cyc.size()), 64'd232);
    check("b_entry_period", 64'((b_rd_cyc.size() >= 2) ? b_rd_cyc[1] - b_rd_cyc[0] : -1), 64'd20);

    // Highlight of entry 2.
    model(0, 1'b1, 1'b0, 20'h00100, 1'b1, 20'h00108);
    start_addr = 20'h00100; hl_en = 1'b1; hl_addr = 20'h00108; a_done_at = -1;
    go_a();
    hl_en = 1'b0;
    wait_a(10000);

    // Abort during entry 10, then check nothing else is written.
    model(0, 1'b1, 1'b0, 20'h00040, 1'b0, 20'h0);
    start_addr = 20'h00040; rd0 = a_rd_cnt; a_done_at = -1;
    go_a();
    n = 0;
    while (a_rd_cnt < rd0 + 11 && n < 2000) begin @(negedge clk); n++; end
    check("abort_reach_entry10", 64'(a_rd_cnt - rd0), 64'd11);
    repeat (5) @(negedge clk);
    check("busy_before_abort", {a_busy, a_done}, 64'd2);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    check("abort_outputs", {a_busy, a_done, a_we, a_rd}, 64'd0);
    q_a.delete();
    repeat (40) @(negedge clk);
    check("abort_stays_idle", {a_busy, a_done, 64'(a_done_at >= 0)}, 64'd0);

    // Normal render after abort; a start while busy must not disturb it.
    model(0, 1'b1, 1'b0, 20'h00200, 1'b0, 20'h0);
    start_addr = 20'h00200;
    go_a();
    repeat (50) @(negedge clk);
    start_addr = 20'h05000; row_major = 1'b1; hl_en = 1'b1; hl_addr = 20'h05000;
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_a(10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
